// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: request/response bundle between the EXE stage and the sequential
// multiply/divide unit.
//   i_MD_start    request to begin an operation
//   i_MD_op       00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   i_MD_srcA/B   multiplicand/dividend, multiplier/divisor
//   i_MD_flush    abort the in-flight operation
//   o_MD_busy     stall request to EXE
//   o_MD_done     one-cycle completion pulse
//   o_MD_hi/lo    architectural HI/LO registers
//   o_MD_divZero  divisor was zero, valid with o_MD_done
// modport master: requester (pipeline / bench); modport slave: the unit itself.
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             i_MD_start;
  logic [1:0]       i_MD_op;
  logic [WIDTH-1:0] i_MD_srcA;
  logic [WIDTH-1:0] i_MD_srcB;
  logic             i_MD_flush;
  logic             o_MD_busy;
  logic             o_MD_done;
  logic [WIDTH-1:0] o_MD_hi;
  logic [WIDTH-1:0] o_MD_lo;
  logic             o_MD_divZero;

  modport master (
    output i_MD_start, i_MD_op, i_MD_srcA, i_MD_srcB, i_MD_flush,
    input  o_MD_busy, o_MD_done, o_MD_hi, o_MD_lo, o_MD_divZero
  );

  modport slave (
    input  i_MD_start, i_MD_op, i_MD_srcA, i_MD_srcB, i_MD_flush,
    output o_MD_busy, o_MD_done, o_MD_hi, o_MD_lo, o_MD_divZero
  );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential radix-2 multiply/divide unit with HI/LO result registers.
// Ports:
//   clk  single clock, rising edge
//   rst  asynchronous active-high reset
//   md   muldiv_seq_if slave modport (start/op/operands/flush in, busy/done/hi/lo/divZero out)
// Operation: signed operands are converted to magnitudes on start, WIDTH shift-add
// (multiply) or restoring shift-subtract (divide) iterations run in BUSY, FIX applies
// the sign correction and loads HI/LO while entering DONE. Divide by zero skips
// straight to DONE. Flush in BUSY/FIX drops the operation without touching HI/LO.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_seq_if.slave  md
);

  localparam int CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StFix,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  // Multiplicand for multiplies, divisor for divides (always a magnitude).
  logic [WIDTH-1:0]   operand_q, operand_d;
  // Multiply: {partial product high, remaining multiplier bits / product low}.
  // Divide:   {partial remainder, dividend bits shifting out / quotient shifting in}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               div_zero_q, div_zero_d;

  // Start-time operand conditioning.
  logic             start_signed;
  logic             start_is_div;
  logic             start_div_zero;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  // Iteration datapath.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_fits;
  logic [2*WIDTH-1:0] div_next;

  // Sign correction.
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quo_fixed;
  logic [WIDTH-1:0]   rem_fixed;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  always_comb begin
    start_signed   = md.i_MD_op[0];
    start_is_div   = md.i_MD_op[1];
    start_div_zero = start_is_div && (md.i_MD_srcB == '0);
    abs_a = (start_signed && md.i_MD_srcA[WIDTH-1]) ? -md.i_MD_srcA : md.i_MD_srcA;
    abs_b = (start_signed && md.i_MD_srcB[WIDTH-1]) ? -md.i_MD_srcB : md.i_MD_srcB;
  end

  always_comb begin
    // Multiply step: conditionally add multiplicand to the high half, shift right.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, operand_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide step: shift next dividend bit into the remainder, try subtract.
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, operand_q};
    div_fits  = ~div_diff[WIDTH];
    div_next  = {(div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], div_fits};
  end

  always_comb begin
    prod_fixed = (op_q[0] && (sign_a_q ^ sign_b_q)) ? -acc_q : acc_q;
    quo_fixed  = (op_q[0] && (sign_a_q ^ sign_b_q)) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    // Remainder follows the dividend's sign (truncating division).
    rem_fixed  = (op_q[0] && sign_a_q) ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    if (op_q[1]) begin
      fix_hi = rem_fixed;
      fix_lo = quo_fixed;
    end else begin
      fix_hi = prod_fixed[2*WIDTH-1:WIDTH];
      fix_lo = prod_fixed[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    operand_d  = operand_q;
    acc_d      = acc_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        // Flush has no effect here; start wins even when flush is also high.
        state_d = StIdle;
        if (md.i_MD_start) begin
          op_d      = md.i_MD_op;
          sign_a_d  = start_signed && md.i_MD_srcA[WIDTH-1];
          sign_b_d  = start_signed && md.i_MD_srcB[WIDTH-1];
          cnt_d     = '0;
          operand_d = start_is_div ? abs_b : abs_a;
          acc_d     = {{WIDTH{1'b0}}, (start_is_div ? abs_a : abs_b)};
          if (start_div_zero) begin
            state_d    = StDone;
            hi_d       = md.i_MD_srcA;
            lo_d       = '1;
            div_zero_d = 1'b1;
          end else begin
            state_d = StBusy;
          end
        end
      end

      StBusy: begin
        if (md.i_MD_flush) begin
          state_d = StIdle;
        end else begin
          acc_d = op_q[1] ? div_next : mul_next;
          if (cnt_q == LastIter) begin
            state_d = StFix;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end

      StFix: begin
        if (md.i_MD_flush) begin
          state_d = StIdle;
        end else begin
          state_d = StDone;
          hi_d    = fix_hi;
          lo_d    = fix_lo;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_q       <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      operand_q  <= '0;
      acc_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      operand_q  <= operand_d;
      acc_q      <= acc_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign md.o_MD_busy    = (state_q == StBusy) || (state_q == StFix);
  assign md.o_MD_done    = (state_q == StDone);
  assign md.o_MD_hi      = hi_q;
  assign md.o_MD_lo      = lo_q;
  assign md.o_MD_divZero = div_zero_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed cases plus randomized operations
// compared against a plain-arithmetic reference model.
module tb_muldiv_seq;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  muldiv_seq_if #(.WIDTH(W)) md ();

  muldiv_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .md  (md)
  );

  // Reference: MIPS-style semantics computed with 64-bit integer arithmetic.
  function automatic void model(input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] hi,
                                output logic [31:0] lo, output logic dz);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    hi = '0;
    lo = '0;
    if (op[1] && b == 32'd0) begin
      hi = a;
      lo = 32'hFFFF_FFFF;
      dz = 1'b1;
    end else begin
      case (op)
        2'd0: begin
          p = {32'h0, a} * {32'h0, b};
          hi = p[63:32];
          lo = p[31:0];
        end
        2'd1: begin
          p = 64'(sa * sb);
          hi = p[63:32];
          lo = p[31:0];
        end
        2'd2: begin
          hi = a % b;
          lo = a / b;
        end
        default: begin
          q = sa / sb;
          r = sa % sb;
          hi = r[31:0];
          lo = q[31:0];
        end
      endcase
    end
  endfunction

  // Issues one start at the current phase (posedge+1) and waits, bounded, for done.
  // edges counts the start-sampling edge as edge 1.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int edges, output int busy_cyc, output logic seen);
    md.i_MD_op    = op;
    md.i_MD_srcA  = a;
    md.i_MD_srcB  = b;
    md.i_MD_start = 1'b1;
    @(posedge clk);
    #1;
    md.i_MD_start = 1'b0;
    edges    = 1;
    busy_cyc = 0;
    seen     = 1'b0;
    while (!seen && edges <= 100) begin
      if (md.o_MD_busy) busy_cyc++;
      if (md.o_MD_done) begin
        seen = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        edges++;
      end
    end
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    md.i_MD_start = 1'b0;
    md.i_MD_op    = 2'd0;
    md.i_MD_srcA  = '0;
    md.i_MD_srcB  = '0;
    md.i_MD_flush = 1'b0;
    #1;
    checks++;
    if (md.o_MD_busy !== 1'b0 || md.o_MD_done !== 1'b0 || md.o_MD_divZero !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags busy=%b done=%b dz=%b exp 0 0 0",
               md.o_MD_busy, md.o_MD_done, md.o_MD_divZero);
    end
    checks++;
    if (md.o_MD_hi !== 32'h0 || md.o_MD_lo !== 32'h0) begin
      failures++;
      $display("FAIL reset_hilo got=%h_%h exp=0_0", md.o_MD_hi, md.o_MD_lo);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (md.o_MD_done !== 1'b0 || md.o_MD_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release busy=%b done=%b exp 0 0", md.o_MD_busy, md.o_MD_done);
    end
  endtask

  task automatic test_multu_max();
    int   e;
    int   bc;
    logic s;
    do_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, e, bc, s);
    checks++;
    if (!s || e !== 34) begin
      failures++;
      $display("FAIL multu_latency seen=%b edges=%0d exp edges=34", s, e);
    end
    checks++;
    if (bc !== 33) begin
      failures++;
      $display("FAIL multu_busy_cycles got=%0d exp=33", bc);
    end
    checks++;
    if (md.o_MD_hi !== 32'hFFFF_FFFE || md.o_MD_lo !== 32'h0000_0001) begin
      failures++;
      $display("FAIL multu_max got=%h_%h exp=fffffffe_00000001", md.o_MD_hi, md.o_MD_lo);
    end
    // Done lasts exactly one cycle; HI/LO hold while idle.
    @(posedge clk);
    #1;
    checks++;
    if (md.o_MD_done !== 1'b0) begin
      failures++;
      $display("FAIL done_one_cycle got=%b exp=0", md.o_MD_done);
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (md.o_MD_hi !== 32'hFFFF_FFFE || md.o_MD_lo !== 32'h0000_0001) begin
      failures++;
      $display("FAIL hilo_hold got=%h_%h exp=fffffffe_00000001", md.o_MD_hi, md.o_MD_lo);
    end
  endtask

  task automatic test_signed();
    int   e;
    int   bc;
    logic s;
    do_op(2'd1, 32'hFFFF_FFFD, 32'd7, e, bc, s);
    checks++;
    if (!s || md.o_MD_hi !== 32'hFFFF_FFFF || md.o_MD_lo !== 32'hFFFF_FFEB) begin
      failures++;
      $display("FAIL mult_neg3x7 seen=%b got=%h_%h exp=ffffffff_ffffffeb",
               s, md.o_MD_hi, md.o_MD_lo);
    end
    do_op(2'd3, 32'hFFFF_FFF9, 32'd2, e, bc, s);
    checks++;
    if (!s || md.o_MD_lo !== 32'hFFFF_FFFD || md.o_MD_hi !== 32'hFFFF_FFFF
        || md.o_MD_divZero !== 1'b0) begin
      failures++;
      $display("FAIL div_neg7by2 seen=%b got hi=%h lo=%h dz=%b exp hi=ffffffff lo=fffffffd dz=0",
               s, md.o_MD_hi, md.o_MD_lo, md.o_MD_divZero);
    end
  endtask

  task automatic test_div_zero();
    int   e;
    int   bc;
    logic s;
    do_op(2'd2, 32'd5, 32'd0, e, bc, s);
    checks++;
    if (!s || e !== 1 || bc !== 0) begin
      failures++;
      $display("FAIL divzero_timing seen=%b edges=%0d busy=%0d exp edges=1 busy=0", s, e, bc);
    end
    checks++;
    if (md.o_MD_divZero !== 1'b1 || md.o_MD_hi !== 32'd5 || md.o_MD_lo !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL divzero_result dz=%b got=%h_%h exp dz=1 00000005_ffffffff",
               md.o_MD_divZero, md.o_MD_hi, md.o_MD_lo);
    end
  endtask

  task automatic test_div_overflow();
    int   e;
    int   bc;
    logic s;
    do_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, e, bc, s);
    checks++;
    if (!s || md.o_MD_lo !== 32'h8000_0000 || md.o_MD_hi !== 32'h0 || md.o_MD_divZero !== 1'b0)
    begin
      failures++;
      $display("FAIL div_overflow seen=%b got hi=%h lo=%h dz=%b exp hi=0 lo=80000000 dz=0",
               s, md.o_MD_hi, md.o_MD_lo, md.o_MD_divZero);
    end
  endtask

  task automatic test_flush();
    logic [31:0] ph;
    logic [31:0] pl;
    int          dones;
    int          busies;
    int          e;
    int          bc;
    logic        s;
    ph = md.o_MD_hi;
    pl = md.o_MD_lo;
    md.i_MD_op    = 2'd2;
    md.i_MD_srcA  = 32'd100;
    md.i_MD_srcB  = 32'd7;
    md.i_MD_start = 1'b1;
    @(posedge clk);
    #1;
    md.i_MD_start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    // A second start mid-operation must be ignored.
    md.i_MD_op    = 2'd0;
    md.i_MD_srcA  = 32'd3;
    md.i_MD_srcB  = 32'd3;
    md.i_MD_start = 1'b1;
    @(posedge clk);
    #1;
    md.i_MD_start = 1'b0;
    checks++;
    if (md.o_MD_busy !== 1'b1 || md.o_MD_done !== 1'b0) begin
      failures++;
      $display("FAIL restart_ignored busy=%b done=%b exp 1 0", md.o_MD_busy, md.o_MD_done);
    end
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    md.i_MD_flush = 1'b1;
    @(posedge clk);
    #1;
    md.i_MD_flush = 1'b0;
    checks++;
    if (md.o_MD_busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_busy got=%b exp=0", md.o_MD_busy);
    end
    dones  = 0;
    busies = 0;
    repeat (40) begin
      if (md.o_MD_done) dones++;
      if (md.o_MD_busy) busies++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (dones !== 0 || busies !== 0) begin
      failures++;
      $display("FAIL flush_no_done dones=%0d busy=%0d exp 0 0", dones, busies);
    end
    checks++;
    if (md.o_MD_hi !== ph || md.o_MD_lo !== pl) begin
      failures++;
      $display("FAIL flush_hilo got=%h_%h exp=%h_%h", md.o_MD_hi, md.o_MD_lo, ph, pl);
    end

    // Flush while in FIX beats the FIX-to-DONE transition.
    md.i_MD_op    = 2'd0;
    md.i_MD_srcA  = 32'h1234_5678;
    md.i_MD_srcB  = 32'h9ABC_DEF1;
    md.i_MD_start = 1'b1;
    @(posedge clk);
    #1;
    md.i_MD_start = 1'b0;
    repeat (32) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (md.o_MD_busy !== 1'b1 || md.o_MD_done !== 1'b0) begin
      failures++;
      $display("FAIL fix_phase busy=%b done=%b exp 1 0", md.o_MD_busy, md.o_MD_done);
    end
    md.i_MD_flush = 1'b1;
    @(posedge clk);
    #1;
    md.i_MD_flush = 1'b0;
    dones = 0;
    repeat (5) begin
      if (md.o_MD_done) dones++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (dones !== 0 || md.o_MD_busy !== 1'b0 || md.o_MD_hi !== ph || md.o_MD_lo !== pl) begin
      failures++;
      $display("FAIL flush_in_fix dones=%0d busy=%b got=%h_%h exp 0 0 %h_%h",
               dones, md.o_MD_busy, md.o_MD_hi, md.o_MD_lo, ph, pl);
    end

    // Start and flush together in IDLE: start wins.
    md.i_MD_op    = 2'd2;
    md.i_MD_srcA  = 32'd100;
    md.i_MD_srcB  = 32'd7;
    md.i_MD_start = 1'b1;
    md.i_MD_flush = 1'b1;
    @(posedge clk);
    #1;
    md.i_MD_start = 1'b0;
    md.i_MD_flush = 1'b0;
    checks++;
    if (md.o_MD_busy !== 1'b1) begin
      failures++;
      $display("FAIL start_with_flush busy=%b exp=1", md.o_MD_busy);
    end
    e  = 1;
    bc = 0;
    s  = 1'b0;
    while (!s && e <= 100) begin
      if (md.o_MD_done) begin
        s = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        e++;
      end
    end
    checks++;
    if (!s || e !== 34 || md.o_MD_lo !== 32'd14 || md.o_MD_hi !== 32'd2) begin
      failures++;
      $display("FAIL divu_100_7 seen=%b edges=%0d got=%h_%h exp edges=34 00000002_0000000e",
               s, e, md.o_MD_hi, md.o_MD_lo);
    end
  endtask

  task automatic test_async_reset();
    int dones;
    int busies;
    md.i_MD_op    = 2'd0;
    md.i_MD_srcA  = 32'hDEAD_BEEF;
    md.i_MD_srcB  = 32'h0000_1234;
    md.i_MD_start = 1'b1;
    @(posedge clk);
    #1;
    md.i_MD_start = 1'b0;
    repeat (19) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (md.o_MD_busy !== 1'b0 || md.o_MD_done !== 1'b0 || md.o_MD_divZero !== 1'b0
        || md.o_MD_hi !== 32'h0 || md.o_MD_lo !== 32'h0) begin
      failures++;
      $display("FAIL async_reset busy=%b done=%b dz=%b hilo=%h_%h exp all 0",
               md.o_MD_busy, md.o_MD_done, md.o_MD_divZero, md.o_MD_hi, md.o_MD_lo);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    dones  = 0;
    busies = 0;
    repeat (40) begin
      if (md.o_MD_done) dones++;
      if (md.o_MD_busy) busies++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (dones !== 0 || busies !== 0) begin
      failures++;
      $display("FAIL post_reset_quiet dones=%0d busy=%0d exp 0 0", dones, busies);
    end
  endtask

  task automatic test_back_to_back();
    int   e;
    int   bc;
    logic s;
    do_op(2'd2, 32'd9, 32'd0, e, bc, s);
    do_op(2'd3, 32'hFFFF_FFF7, 32'd0, e, bc, s);
    checks++;
    if (!s || e !== 1 || md.o_MD_hi !== 32'hFFFF_FFF7 || md.o_MD_lo !== 32'hFFFF_FFFF
        || md.o_MD_divZero !== 1'b1) begin
      failures++;
      $display("FAIL b2b_divzero seen=%b edges=%0d got=%h_%h dz=%b exp 1 fffffff7_ffffffff 1",
               s, e, md.o_MD_hi, md.o_MD_lo, md.o_MD_divZero);
    end
    do_op(2'd0, 32'd6, 32'd7, e, bc, s);
    checks++;
    if (!s || e !== 34 || md.o_MD_hi !== 32'd0 || md.o_MD_lo !== 32'd42
        || md.o_MD_divZero !== 1'b0) begin
      failures++;
      $display("FAIL b2b_multu seen=%b edges=%0d got=%h_%h dz=%b exp 34 0_2a 0",
               s, e, md.o_MD_hi, md.o_MD_lo, md.o_MD_divZero);
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
    logic        edz;
    int          sel;
    int          e;
    int          bc;
    logic        s;
    for (int i = 0; i < 60; i++) begin
      op  = 2'($urandom_range(0, 3));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 16));
        2: begin
          a = 32'h8000_0000;
          b = 32'hFFFF_FFFF;
        end
        3: b = -32'($urandom_range(1, 16));
        default: ;
      endcase
      model(op, a, b, ehi, elo, edz);
      do_op(op, a, b, e, bc, s);
      checks++;
      if (!s || md.o_MD_hi !== ehi || md.o_MD_lo !== elo || md.o_MD_divZero !== edz
          || e !== (edz ? 1 : 34)) begin
        failures++;
        $display("FAIL random op=%0d a=%h b=%h seen=%b edges=%0d got=%h_%h dz=%b exp=%h_%h dz=%b",
                 op, a, b, s, e, md.o_MD_hi, md.o_MD_lo, md.o_MD_divZero, ehi, elo, edz);
      end
    end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_signed();
    test_div_zero();
    test_div_overflow();
    test_flush();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width and the iteration count.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port i_MD_start, input, 1 bit: request to begin an operation, sampled on a rising edge.
REQ-005 The block SHALL have port i_MD_op, input, 2 bits: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 The block SHALL have ports i_MD_srcA and i_MD_srcB, input, WIDTH bits: multiplicand/dividend and multiplier/divisor.
REQ-007 The block SHALL have port i_MD_flush, input, 1 bit: abort the in-flight operation.
REQ-008 The block SHALL have port o_MD_busy, output, 1 bit: stall request to the EXE stage.
REQ-009 The block SHALL have port o_MD_done, output, 1 bit: one-cycle completion pulse.
REQ-010 The block SHALL have ports o_MD_hi and o_MD_lo, output, WIDTH bits each: architectural HI and LO registers.
REQ-011 The block SHALL have port o_MD_divZero, output, 1 bit: divisor was zero, valid while o_MD_done is high.

Function
REQ-012 The block SHALL implement FSM states IDLE, BUSY, FIX and DONE; o_MD_busy SHALL be 1 exactly in BUSY and FIX.
REQ-013 In IDLE or DONE, a rising edge with i_MD_start=1 SHALL latch the operands and op, and load the iteration counter with 0.
- Signed ops: latch absolute values; record sign of A and sign of B.
- That edge enters BUSY, or enters DONE directly for DIV/DIVU with srcB=0.
REQ-014 i_MD_start SHALL be ignored in BUSY and FIX.
REQ-015 BUSY SHALL perform one radix-2 iteration per edge:
- multiply: shift-add into a 2*WIDTH accumulator.
- divide: restoring shift-subtract.
REQ-016 BUSY SHALL leave for FIX on the edge that completes iteration WIDTH (counter reaches WIDTH-1); the counter SHALL not wrap.
REQ-017 FIX SHALL apply sign correction in one edge, then enter DONE, loading o_MD_hi and o_MD_lo on that same edge.
- MULT: negate the 64-bit product when the signs differ.
- DIV: quotient sign = signA XOR signB; remainder sign = signA.
REQ-018 Results loaded on entry to DONE SHALL be:
- MULT/MULTU: {o_MD_hi, o_MD_lo} = full 2*WIDTH product.
- DIV/DIVU: o_MD_lo = quotient, o_MD_hi = remainder.
REQ-019 DIV of the most negative value by -1 SHALL give o_MD_lo=0x80000000, o_MD_hi=0, with no flag.
REQ-020 Divide by zero SHALL give o_MD_hi=srcA, o_MD_lo=all ones and o_MD_divZero=1 in DONE.
REQ-021 o_MD_done SHALL be 1 only in DONE, exactly one cycle per completed operation.
REQ-022 DONE SHALL go to IDLE on the next edge, or to BUSY when i_MD_start=1.
REQ-023 Latency SHALL be WIDTH+2 edges from the start-sampling edge to the edge entering DONE, and 1 edge for divide by zero.
REQ-024 i_MD_flush=1 in BUSY or FIX SHALL return the FSM to IDLE on the next edge.
- o_MD_hi and o_MD_lo unchanged; no o_MD_done pulse.
- Flush SHALL take priority over the FIX-to-DONE transition.
REQ-025 i_MD_flush in IDLE or DONE SHALL have no effect; simultaneous i_MD_start and i_MD_flush in IDLE SHALL start the operation.
REQ-026 o_MD_hi and o_MD_lo SHALL change only on entry to DONE and SHALL hold between operations.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, counter 0, and o_MD_hi, o_MD_lo, o_MD_busy, o_MD_done and o_MD_divZero to 0, regardless of clk.
REQ-028 Reset asserted mid-operation SHALL discard the operation; no o_MD_done pulse SHALL follow reset release.

Verification
REQ-029 MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; done on the 34th edge after start; busy high for 33 cycles.
REQ-030 MULT -3*7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-031 DIVU 5/0 -> done 1 edge after start, divZero=1, HI=0x00000005, LO=0xFFFFFFFF, busy never high.
REQ-032 Start DIVU 100/7, pulse start again mid-BUSY, then flush at iteration 10 -> second start ignored, busy low next cycle, no done, HI/LO keep prior values.
REQ-033 DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0, divZero=0.
REQ-034 Assert rst during iteration 20 between clock edges -> all outputs 0 immediately; after release, no done until a new start.
